// File: rtl/dir_cmd_queue.sv
// Turn-command queue: arbitrates key/IR direction requests, filters null turns
// and reversals, and buffers them in a FIFO that game_logic pops one per move tick.
// Ports: sys_clk/sys_rst_n; kf_up/down/left/right; ir_data_en/ir_data;
//   game_tick/game_run/game_init in; cur_dir, dir_changed, q_count, q_full, drop_cnt out.
// Optional IR decode: define DIR_CMD_IR_EN (otherwise ir_data/ir_data_en are ignored).
module dir_cmd_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [1:0]  INIT_DIR = 2'd3,
  parameter logic [7:0]  IR_UP    = 8'h18,
  parameter logic [7:0]  IR_DOWN  = 8'h52,
  parameter logic [7:0]  IR_LEFT  = 8'h08,
  parameter logic [7:0]  IR_RIGHT = 8'h5A,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          kf_up,
  input  logic          kf_down,
  input  logic          kf_left,
  input  logic          kf_right,
  input  logic          ir_data_en,
  input  logic [7:0]    ir_data,
  input  logic          game_tick,
  input  logic          game_run,
  input  logic          game_init,
  output logic [1:0]    cur_dir,
  output logic          dir_changed,
  output logic [CW-1:0] q_count,
  output logic          q_full,
  output logic [7:0]    drop_cnt
);

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          ir_req;
  logic [1:0]    ir_dir;
  logic [4:0]    req_vec;
  logic          has_req;
  logic          multi;
  logic [1:0]    cmd;
  logic [1:0]    ref_dir;
  logic          pass;
  logic          pop;
  logic          push;
  logic          ovf;
  logic [CW-1:0] cnt_nxt;
  logic [8:0]    drop_sum;
  logic [7:0]    drop_nxt;

`ifdef DIR_CMD_IR_EN
  always_comb begin
    ir_req = ir_data_en;
    ir_dir = 2'd0;
    if (ir_data == IR_UP)         ir_dir = 2'd0;
    else if (ir_data == IR_DOWN)  ir_dir = 2'd1;
    else if (ir_data == IR_LEFT)  ir_dir = 2'd2;
    else if (ir_data == IR_RIGHT) ir_dir = 2'd3;
    else                          ir_req = 1'b0;
  end
`else
  logic ir_unused;
  assign ir_unused = ^{ir_data, ir_data_en};
  assign ir_req    = 1'b0;
  assign ir_dir    = 2'd0;
`endif

  assign req_vec = {kf_up, kf_down, kf_left, kf_right, ir_req};
  assign has_req = |req_vec;
  assign multi   = $countones(req_vec) > 1;

  // Fixed priority: up > down > left > right > IR
  always_comb begin
    cmd = ir_dir;
    if (kf_up)         cmd = 2'd0;
    else if (kf_down)  cmd = 2'd1;
    else if (kf_left)  cmd = 2'd2;
    else if (kf_right) cmd = 2'd3;
  end

  // Compare against the newest queued turn so chained turns are judged
  // relative to where the snake will be heading, not where it is now.
  assign ref_dir = (q_count != '0) ? mem[wr_ptr - 1'b1] : cur_dir;
  assign pass    = has_req && (cmd != ref_dir) && (cmd != (ref_dir ^ 2'b01));

  assign pop  = game_tick && game_run && (q_count != '0);
  assign push = game_run && pass && (!q_full || pop);
  assign ovf  = game_run && pass && q_full && !pop;

  assign cnt_nxt  = q_count + CW'(push) - CW'(pop);
  assign drop_sum = {1'b0, drop_cnt} + 9'(multi) + 9'(ovf);
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge sys_clk) begin
    if (push && !game_init) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_dir     <= INIT_DIR;
      dir_changed <= 1'b0;
      q_count     <= '0;
      q_full      <= 1'b0;
      drop_cnt    <= 8'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (game_init) begin
      cur_dir     <= INIT_DIR;
      dir_changed <= 1'b0;
      q_count     <= '0;
      q_full      <= 1'b0;
      drop_cnt    <= 8'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      dir_changed <= pop;
      q_count     <= cnt_nxt;
      q_full      <= (cnt_nxt == CW'(DEPTH));
      drop_cnt    <= drop_nxt;
      if (pop) begin
        cur_dir <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule
